// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared widths, default clear key code and scheduler FSM state
//               encoding for the colour frame scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int COLR_W = 3;
  localparam int KEY_W  = 6;

  // Key code that restores the default colour unless overridden at the top.
  localparam logic [KEY_W-1:0] CLEAR_CODE = 6'h3F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    APPLY = 2'd2,
    HOLD  = 2'd3
  } schedState_t;

endpackage
`default_nettype wire

// File: rtl/colr_frame_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : colr_frame_sched_if
// Description : Key command input, vsync input and colour/status outputs of
//               the colour frame scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface colr_frame_sched_if
  import vga_pkg::*;
#(
  parameter int PEND_W = 3
);

  logic              keyValid;
  logic [KEY_W-1:0]  keyCode;
  logic              vgaVsync;
  logic [COLR_W-1:0] outColr;
  logic              colrUpdate;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  // Driver side: key decode path and display controller sync.
  modport master (
    output keyValid,
    output keyCode,
    output vgaVsync,
    input  outColr,
    input  colrUpdate,
    input  pending,
    input  overflow
  );

  // Scheduler side.
  modport slave (
    input  keyValid,
    input  keyCode,
    input  vgaVsync,
    output outColr,
    output colrUpdate,
    output pending,
    output overflow
  );

endinterface
`default_nettype wire

// File: rtl/colr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : colr_fifo
// Description : Synchronous FIFO with registered occupancy count. A push in
//               the same cycle as a pop is accepted even when full, since the
//               pop frees the slot on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module colr_fifo #(
  parameter int DEPTH = 4,   // power of two, minimum 2
  parameter int WIDTH = 3
) (
  input  wire logic                       boardClk,
  input  wire logic                       reset,
  input  wire logic                       push,
  input  wire logic [WIDTH-1:0]           pushData,
  input  wire logic                       pop,
  output logic      [WIDTH-1:0]           popData,
  output logic      [$clog2(DEPTH):0]     count,
  output logic                            full
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wrPtr;
  logic [c_PTR_W-1:0] r_rdPtr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_doPop;
  logic               w_doPush;

  assign w_doPop  = pop && (r_count != '0);
  assign w_doPush = push && ((r_count != c_FULL) || w_doPop);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge boardClk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= pushData;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge boardClk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign popData = r_mem[r_rdPtr];
  assign count   = r_count;
  assign full    = (r_count == c_FULL);

endmodule
`default_nettype wire

// File: rtl/colr_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : colr_frame_sched
// Description : Queues validated key colour commands and applies at most one
//               per video frame, on the falling edge of the synchronized
//               vertical sync, so colour never changes mid-frame.
// Revision    : 1.0 - initial release
// ============================================================================
module colr_frame_sched
  import vga_pkg::*;
#(
  parameter int                FIFO_DEPTH   = 4,
  parameter logic [COLR_W-1:0] DEFAULT_COLR = 3'b111,
  parameter logic [KEY_W-1:0]  CLEAR_CODE   = vga_pkg::CLEAR_CODE
) (
  input wire logic            boardClk,
  input wire logic            reset,
  colr_frame_sched_if.slave   bus
);

  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic               r_vsyncMeta;
  logic               r_vsyncSync;
  logic               r_vsyncHist;
  logic               w_frameEvent;

  schedState_t        r_state;
  schedState_t        w_nextState;

  logic               w_isClear;
  logic               w_isValid;
  logic [COLR_W-1:0]  w_payload;
  logic               w_push;
  logic               w_pop;
  logic [COLR_W-1:0]  w_headColr;
  logic [c_CNT_W-1:0] w_count;
  logic               w_full;

  logic [COLR_W-1:0]  r_outColr;
  logic               r_colrUpdate;
  logic               r_overflow;

  // Command decode: low-range codes carry a colour, the clear code restores default.
  assign w_isClear = (bus.keyCode == CLEAR_CODE);
  assign w_isValid = (bus.keyCode[5:3] == 3'b000) || w_isClear;
  assign w_payload = w_isClear ? DEFAULT_COLR : bus.keyCode[2:0];
  assign w_push    = bus.keyValid && w_isValid;
  assign w_pop     = (r_state == APPLY);

  colr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (COLR_W)
  ) u_fifo (
    .boardClk (boardClk),
    .reset    (reset),
    .push     (w_push),
    .pushData (w_payload),
    .pop      (w_pop),
    .popData  (w_headColr),
    .count    (w_count),
    .full     (w_full)
  );

  // Two-flop synchronizer plus history flop; idle level of vsync is high.
  always_ff @(posedge boardClk or negedge reset) begin
    if (!reset) begin
      r_vsyncMeta <= 1'b1;
      r_vsyncSync <= 1'b1;
      r_vsyncHist <= 1'b1;
    end else begin
      r_vsyncMeta <= bus.vgaVsync;
      r_vsyncSync <= r_vsyncMeta;
      r_vsyncHist <= r_vsyncSync;
    end
  end

  assign w_frameEvent = r_vsyncHist && !r_vsyncSync;

  // Scheduler state register.
  always_ff @(posedge boardClk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; events seen outside ARMED are deliberately dropped.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_count != '0) w_nextState = ARMED;
      ARMED:   if (w_frameEvent)  w_nextState = APPLY;
      APPLY:   w_nextState = HOLD;
      HOLD:    if (r_vsyncSync)   w_nextState = (w_count != '0) ? ARMED : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Registered colour output and its one-cycle update strobe.
  always_ff @(posedge boardClk or negedge reset) begin
    if (!reset) begin
      r_outColr    <= DEFAULT_COLR;
      r_colrUpdate <= 1'b0;
    end else begin
      r_colrUpdate <= (r_state == APPLY);
      if (r_state == APPLY) begin
        r_outColr <= w_headColr;
      end
    end
  end

  // Sticky drop flag; a push in the APPLY cycle is never a drop.
  always_ff @(posedge boardClk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.outColr    = r_outColr;
  assign bus.colrUpdate = r_colrUpdate;
  assign bus.pending    = w_count;
  assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_colr_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_colr_frame_sched
// Description : Directed self-checking bench for colr_frame_sched with a
//               queue scoreboard of expected colours.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_colr_frame_sched;

  logic boardClk;
  logic reset;

  colr_frame_sched_if #(.PEND_W(3)) bus ();

  colr_frame_sched #(
    .FIFO_DEPTH   (4),
    .DEFAULT_COLR (3'b111),
    .CLEAR_CODE   (6'h3F)
  ) dut (
    .boardClk (boardClk),
    .reset    (reset),
    .bus      (bus)
  );

  initial begin
    boardClk = 1'b0;
    forever #5 boardClk = ~boardClk;
  end

  int         checks   = 0;
  int         failures = 0;
  logic [2:0] expQ[$];
  logic [2:0] curColr;
  logic       expOvf;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit isValid(input logic [5:0] code);
    return (code[5:3] == 3'b000) || (code == 6'h3F);
  endfunction

  function automatic logic [2:0] payloadOf(input logic [5:0] code);
    return (code == 6'h3F) ? 3'b111 : code[2:0];
  endfunction

  // One keyValid strobe; model queue follows the depth-4 drop rule.
  task automatic pushKey(input logic [5:0] code);
    @(negedge boardClk);
    bus.keyValid = 1'b1;
    bus.keyCode  = code;
    if (isValid(code)) begin
      if (expQ.size() < 4) expQ.push_back(payloadOf(code));
      else                 expOvf = 1'b1;
    end
    @(negedge boardClk);
    bus.keyValid = 1'b0;
    check("pending_after_push", 8'(bus.pending), 8'(expQ.size()));
    check("overflow_after_push", 8'(bus.overflow), 8'(expOvf));
  endtask

  // One vsync pulse; cycle k is the k-th cycle after the first edge sampling low.
  task automatic doFrame(input bit inject, input logic [5:0] injCode);
    int pulses;
    int pulseAt;
    bit expUpd;
    pulses  = 0;
    pulseAt = 0;
    @(negedge boardClk);
    expUpd       = (expQ.size() != 0);
    bus.vgaVsync = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge boardClk);
      if (k == 8) bus.vgaVsync = 1'b1;
      if (bus.colrUpdate) begin
        pulses++;
        pulseAt = k;
        if (expQ.size() != 0) curColr = expQ.pop_front();
        check("update_colour", 8'(bus.outColr), 8'(curColr));
      end
      if (inject && k == 3) begin
        bus.keyValid = 1'b1;
        bus.keyCode  = injCode;
        expQ.push_back(payloadOf(injCode));
      end
      if (inject && k == 4) bus.keyValid = 1'b0;
    end
    check("update_count", 8'(pulses), expUpd ? 8'd1 : 8'd0);
    if (expUpd) check("update_latency", 8'(pulseAt), 8'd4);
    check("colour_hold", 8'(bus.outColr), 8'(curColr));
    check("pending_after_frame", 8'(bus.pending), 8'(expQ.size()));
  endtask

  // Directed sequence.
  initial begin
    reset        = 1'b0;
    bus.keyValid = 1'b0;
    bus.keyCode  = 6'h00;
    bus.vgaVsync = 1'b1;
    curColr      = 3'b111;
    expOvf       = 1'b0;

    repeat (3) @(negedge boardClk);
    check("reset_colour", 8'(bus.outColr), 8'h07);
    check("reset_update", 8'(bus.colrUpdate), 8'h00);
    check("reset_pending", 8'(bus.pending), 8'h00);
    check("reset_overflow", 8'(bus.overflow), 8'h00);
    reset = 1'b1;
    repeat (2) @(negedge boardClk);

    // Idle frames: no updates, colour stays default.
    doFrame(1'b0, 6'h00);
    doFrame(1'b0, 6'h00);

    // Single command, applied at the next frame.
    pushKey(6'h04);
    doFrame(1'b0, 6'h00);

    // Three commands, one per frame in order.
    pushKey(6'h01);
    pushKey(6'h02);
    pushKey(6'h03);
    doFrame(1'b0, 6'h00);
    doFrame(1'b0, 6'h00);
    doFrame(1'b0, 6'h00);

    // Ignored code, then clear back to default.
    pushKey(6'h15);
    pushKey(6'h02);
    doFrame(1'b0, 6'h00);
    pushKey(6'h3F);
    doFrame(1'b0, 6'h00);
    check("clear_colour", 8'(bus.outColr), 8'h07);

    // Fill, drop the fifth, then a push in the APPLY cycle while full.
    pushKey(6'h05);
    pushKey(6'h06);
    pushKey(6'h07);
    pushKey(6'h01);
    pushKey(6'h02);
    doFrame(1'b1, 6'h03);
    doFrame(1'b0, 6'h00);
    doFrame(1'b0, 6'h00);
    doFrame(1'b0, 6'h00);
    doFrame(1'b0, 6'h00);
    check("overflow_sticky", 8'(bus.overflow), 8'h01);

    // Reset in the middle of the APPLY cycle.
    pushKey(6'h04);
    pushKey(6'h05);
    @(negedge boardClk);
    bus.vgaVsync = 1'b0;
    repeat (3) @(negedge boardClk);
    reset = 1'b0;
    #1;
    check("midapply_colour", 8'(bus.outColr), 8'h07);
    check("midapply_update", 8'(bus.colrUpdate), 8'h00);
    check("midapply_pending", 8'(bus.pending), 8'h00);
    check("midapply_overflow", 8'(bus.overflow), 8'h00);
    @(negedge boardClk);
    reset        = 1'b1;
    bus.vgaVsync = 1'b1;
    expQ.delete();
    curColr = 3'b111;
    expOvf  = 1'b0;
    repeat (4) @(negedge boardClk);
    doFrame(1'b0, 6'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/colr_frame_sched.md
# colr_frame_sched

Frame-synchronous scheduler between the PS/2 decode path and the display controller. It accepts key-command strobes in the boardClk domain, validates and queues them, and applies at most one colour change per video frame, exactly at the start of vertical sync, so the display never changes colour mid-frame. Its 3-bit colour output replaces the direct decode-to-display connection and feeds the display controller's colour input.

## Interface
- FIFO_DEPTH, 4: command queue depth; power of two, minimum 2.
- DEFAULT_COLR, 3'b111: colour after reset and after a clear command.
- CLEAR_CODE, 6'h3F: key code that restores DEFAULT_COLR.

Ports:
- boardClk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- keyValid  in  1  one-cycle strobe; keyCode is valid this cycle.
- keyCode  in  6  decoded PS/2 command code.
- vgaVsync  in  1  vertical sync from the display controller; active-low; asynchronous to boardClk.
- outColr  out  3  current colour to the display controller.
- colrUpdate  out  1  one-cycle pulse in the cycle outColr takes a new value.
- pending  out  log2(FIFO_DEPTH)+1  number of queued commands.
- overflow  out  1  sticky flag; set when a valid command is dropped because the queue is full.

## Operation
- Command validity:
  - keyCode[5:3]==3'b000 is a set-colour command; the payload is keyCode[2:0].
  - keyCode==CLEAR_CODE is a set-colour command with payload DEFAULT_COLR.
  - All other codes are ignored: not queued, no flag.
- Push: keyValid with a valid code and the queue not full writes the payload.
- Full queue: keyValid with a valid code drops the payload and sets overflow. overflow clears only on reset.
- vgaVsync passes through a 2-flop synchronizer plus one history flop. The falling edge of the synchronized signal is the frame event.
- FSM states and transitions:
  - IDLE: queue empty. Goes to ARMED when pending becomes non-zero.
  - ARMED: waits for the frame event. On the event goes to APPLY.
  - APPLY: one cycle. Pops the head, loads outColr, pulses colrUpdate, then goes to HOLD.
  - HOLD: waits for the synchronized vsync to return high. Then goes to ARMED if pending>0, else IDLE.
- Rate rules:
  - Exactly one command is applied per frame event, and only one event is counted per vsync pulse.
  - A frame event that occurs while in IDLE or HOLD is not remembered.
- Simultaneous push and pop (APPLY cycle): both take effect and pending is unchanged. A push arriving when the queue is full during the APPLY cycle is accepted, because the pop frees a slot in the same cycle.
- Reset (any time, including mid-APPLY):
  - outColr=DEFAULT_COLR, colrUpdate=0, pending=0, overflow=0, FSM=IDLE.
  - Synchronizer flops reset to 1 (the vsync inactive level).
  - Queue contents are discarded.

## Timing
- Push latency: pending increments on the clock edge following the keyValid cycle.
- Apply latency: when vgaVsync falls while the FSM is ARMED, colrUpdate is high in the 4th boardClk cycle after the first edge that samples vgaVsync low. outColr changes on that same edge.
- All outputs are registered and have no combinational path from inputs.
- Pointers wrap modulo FIFO_DEPTH. Full when pending==FIFO_DEPTH; empty when pending==0.

## Structure
- Shared package vga_pkg holds:
  - COLR_W=3 and KEY_W=6.
  - The CLEAR_CODE default.
  - The FSM state enum: IDLE, ARMED, APPLY, HOLD.
- One sub-module, colr_fifo: a synchronous FIFO with registered count, parameterized by depth and width, with the simultaneous push/pop rule above.
- The synchronizer, edge detect and FSM live in the top of colr_frame_sched.

## Test plan
- Reset, then no input for 2 frames → outColr=3'b111, colrUpdate never pulses, pending=0.
- keyCode=6'h04 pushed mid-frame → pending=1; at the next vgaVsync fall, outColr=3'b100 with a single colrUpdate pulse at the 4-cycle latency; pending=0.
- Push 6'h01, 6'h02, 6'h03 in one frame → applied one per frame over 3 consecutive frames, in order 001, 010, 011.
- Push 5 valid codes with FIFO_DEPTH=4 → pending=4, overflow=1, the 5th payload is never applied; then a push exactly in an APPLY cycle while full is accepted.
- keyCode=6'h15 ignored (pending stays 0, overflow stays 0); keyCode=6'h3F after colour 3'b010 → outColr back to 3'b111 at the next frame.
- reset asserted during the APPLY cycle → outputs immediately return to reset values and the queue is empty afterwards.
